// File: rtl/regfile_2w2r.sv
// Two-write, two-read register file with a post-reset clear sweep, write/write arbitration
// and a saturating read/write collision counter. Optional parity storage: REGFILE_PARITY_EN.
module regfile_2w2r #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned BYPASS     = 0,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] din1,
  input  logic [ADDR_WIDTH-1:0] wad1,
  input  logic                  wen1,
  input  logic [DATA_WIDTH-1:0] din2,
  input  logic [ADDR_WIDTH-1:0] wad2,
  input  logic                  wen2,
  input  logic [ADDR_WIDTH-1:0] rad1,
  input  logic                  ren1,
  input  logic [ADDR_WIDTH-1:0] rad2,
  input  logic                  ren2,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic [DATA_WIDTH-1:0] dout2,
  output logic                  rvalid1,
  output logic                  rvalid2,
  output logic                  collision,
  output logic                  ww_conflict,
  output logic [CNT_WIDTH-1:0]  coll_count,
  output logic                  ready,
  output logic                  parity_err1,
  output logic                  parity_err2
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic                    ready_q, ready_d;
  logic [DATA_WIDTH-1:0]   dout1_q, dout1_d;
  logic [DATA_WIDTH-1:0]   dout2_q, dout2_d;
  logic                    rvalid1_q, rvalid1_d;
  logic                    rvalid2_q, rvalid2_d;
  logic                    coll_q, coll_d;
  logic                    ww_q, ww_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  // Array write channels: channel 1 doubles as the clear-sweep port during INIT
  logic                    arr_we1, arr_we2;
  logic [ADDR_WIDTH-1:0]   arr_wa1, arr_wa2;
  logic [DATA_WIDTH-1:0]   arr_wd1, arr_wd2;

  logic                    accept;
  logic                    we1, we2, re1, re2;
  logic                    hit11, hit21, hit12, hit22;
  logic                    byp1, byp2;
  logic [DATA_WIDTH-1:0]   rd1, rd2;

  // Qualified access strobes and read-during-write selection
  always_comb begin
    accept = (state_q == ST_READY);
    we1    = accept & wen1;
    we2    = accept & wen2;
    re1    = accept & ren1;
    re2    = accept & ren2;
    hit11  = we1 & (wad1 == rad1);
    hit21  = we2 & (wad2 == rad1);
    hit12  = we1 & (wad1 == rad2);
    hit22  = we2 & (wad2 == rad2);
    byp1   = (BYPASS != 0) & (hit11 | hit21);
    byp2   = (BYPASS != 0) & (hit12 | hit22);
    rd1    = mem_q[rad1];
    rd2    = mem_q[rad2];
    if (byp1) rd1 = hit21 ? din2 : din1;
    if (byp2) rd2 = hit22 ? din2 : din1;
  end

  always_comb begin
    arr_we1 = we1;
    arr_wa1 = wad1;
    arr_wd1 = din1;
    arr_we2 = we2;
    arr_wa2 = wad2;
    arr_wd2 = din2;
    if (state_q == ST_INIT) begin
      arr_we1 = 1'b1;
      arr_wa1 = ptr_q;
      arr_wd1 = '0;
    end
  end

  // Port 2 is applied last so it wins a same-address write
  always_ff @(posedge clk) begin
    if (arr_we1) mem_q[arr_wa1] <= arr_wd1;
    if (arr_we2) mem_q[arr_wa2] <= arr_wd2;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    dout1_d   = dout1_q;
    dout2_d   = dout2_q;
    rvalid1_d = 1'b0;
    rvalid2_d = 1'b0;
    coll_d    = 1'b0;
    ww_d      = 1'b0;
    cnt_d     = cnt_q;

    case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + ADDR_WIDTH'(1);
        if (ptr_q == PTR_LAST) begin
          state_d = ST_READY;
          ptr_d   = '0;
        end
      end
      ST_READY: begin
        if (re1) begin
          dout1_d   = rd1;
          rvalid1_d = 1'b1;
        end
        if (re2) begin
          dout2_d   = rd2;
          rvalid2_d = 1'b1;
        end
        ww_d   = we1 & we2 & (wad1 == wad2);
        coll_d = (re1 & (hit11 | hit21)) | (re2 & (hit12 | hit22));
        if (clr) begin
          state_d = ST_INIT;
          ptr_d   = '0;
          cnt_d   = '0;
        end else if (coll_d && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_INIT;
        ptr_d   = '0;
      end
    endcase

    ready_d = (state_d == ST_READY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_INIT;
      ptr_q     <= '0;
      ready_q   <= 1'b0;
      dout1_q   <= '0;
      dout2_q   <= '0;
      rvalid1_q <= 1'b0;
      rvalid2_q <= 1'b0;
      coll_q    <= 1'b0;
      ww_q      <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      ready_q   <= ready_d;
      dout1_q   <= dout1_d;
      dout2_q   <= dout2_d;
      rvalid1_q <= rvalid1_d;
      rvalid2_q <= rvalid2_d;
      coll_q    <= coll_d;
      ww_q      <= ww_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef REGFILE_PARITY_EN
  logic                    par_q [DEPTH];
  logic                    perr1_q, perr1_d;
  logic                    perr2_q, perr2_d;

  // Stored bit makes data+parity even; the sweep stores 0 alongside zero data
  always_ff @(posedge clk) begin
    if (arr_we1) par_q[arr_wa1] <= ^arr_wd1;
    if (arr_we2) par_q[arr_wa2] <= ^arr_wd2;
  end

  always_comb begin
    perr1_d = perr1_q;
    perr2_d = perr2_q;
    if (re1) perr1_d = byp1 ? 1'b0 : ((^mem_q[rad1]) ^ par_q[rad1]);
    if (re2) perr2_d = byp2 ? 1'b0 : ((^mem_q[rad2]) ^ par_q[rad2]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perr1_q <= 1'b0;
      perr2_q <= 1'b0;
    end else begin
      perr1_q <= perr1_d;
      perr2_q <= perr2_d;
    end
  end

  assign parity_err1 = perr1_q;
  assign parity_err2 = perr2_q;
`else
  assign parity_err1 = 1'b0;
  assign parity_err2 = 1'b0;
`endif

  assign ready       = ready_q;
  assign dout1       = dout1_q;
  assign dout2       = dout2_q;
  assign rvalid1     = rvalid1_q;
  assign rvalid2     = rvalid2_q;
  assign collision   = coll_q;
  assign ww_conflict = ww_q;
  assign coll_count  = cnt_q;

endmodule

// File: doc/regfile_2w2r.md
Name: regfile_2w2r

Overview:
- Parametrised two-write, two-read register file. Successor to the single-write 32-entry register file.
- Adds configurable depth, a second write port and write/write conflict resolution.
- Adds selectable read-during-write mode, a saturating collision counter, and a post-reset clear sweep FSM.
- Sits in the datapath as the general-purpose operand store.

Parameters:
- DATA_WIDTH, 16, word width in bits
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH entries
- BYPASS, 0, read-during-write mode: 0 = old data, 1 = new data
- CNT_WIDTH, 8, width of collision counter

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- clr  in  1  synchronous request to re-zero array and counter
- din1  in  DATA_WIDTH  write data, port 1
- wad1  in  ADDR_WIDTH  write address, port 1
- wen1  in  1  write enable, port 1
- din2  in  DATA_WIDTH  write data, port 2
- wad2  in  ADDR_WIDTH  write address, port 2
- wen2  in  1  write enable, port 2
- rad1  in  ADDR_WIDTH  read address, port 1
- ren1  in  1  read enable, port 1
- rad2  in  ADDR_WIDTH  read address, port 2
- ren2  in  1  read enable, port 2
- dout1  out  DATA_WIDTH  registered read data, port 1
- dout2  out  DATA_WIDTH  registered read data, port 2
- rvalid1  out  1  dout1 updated this cycle
- rvalid2  out  1  dout2 updated this cycle
- collision  out  1  registered read/write address match flag
- ww_conflict  out  1  registered write/write address match flag
- coll_count  out  CNT_WIDTH  saturating count of collision cycles
- ready  out  1  array initialised, accesses accepted
- parity_err1  out  1  parity error, port 1 (see Optional Feature)
- parity_err2  out  1  parity error, port 2 (see Optional Feature)

Behaviour:
- Reset (async, active-high): all outputs 0; FSM enters INIT with sweep pointer 0. Array contents undefined until the sweep completes.
- FSM INIT:
  - Writes 0 to entry ptr each cycle; ptr increments.
  - After entry DEPTH-1 is cleared, moves to READY. ready rises on the edge after the last clear.
  - INIT therefore lasts exactly DEPTH cycles after reset deassertion.
- FSM READY: ready=1; accesses accepted. clr=1 in READY moves to INIT (ptr=0) and zeroes coll_count on the same edge.
- During INIT: wen*/ren* ignored; rvalid*=0; dout* hold; collision, ww_conflict = 0; clr ignored.
- Write: entry written on the edge where wenN=1 and ready=1.
- Write/write conflict: if wen1 & wen2 & wad1==wad2, port 2 data is stored and ww_conflict=1 the following cycle; otherwise ww_conflict=0.
- Read: latency 1.
  - On the edge where renN=1 and ready=1, doutN <= entry[radN] and rvalidN <= 1.
  - Otherwise doutN holds and rvalidN <= 0.
- Read-during-write (same edge, same address):
  - BYPASS=0: returns the pre-write value.
  - BYPASS=1: returns the winning write data (port 2 if both ports write that address).
- Both read ports may address the same entry; no conflict is raised.
- collision: registered.
  - Set to 1 for one cycle after an edge where ready=1 and any enabled write address equals any enabled read address.
  - Otherwise 0.
- coll_count: increments on each edge that sets collision=1. Saturates at 2**CNT_WIDTH-1; never wraps.
- Reset mid-sweep or mid-access: aborts immediately; INIT restarts from entry 0 after deassertion.

Optional Feature:
- Macro: REGFILE_PARITY_EN.
- Defined:
  - Each entry stores one extra even-parity bit computed from write data. The INIT sweep writes parity 0.
  - On each accepted read, parity_errN <= recomputed parity XOR stored bit, aligned with doutN/rvalidN.
  - Bypassed reads report parity_errN=0.
- Not defined: no parity storage; parity_err1/2 are constant 0.

Test Plan:
- Reset pulse, then hold idle -> ready=0 for exactly 32 cycles (defaults), then 1; reads of entries 0, 15, 31 return 0x0000 with rvalid1=1 one cycle after ren1.
- wen1, wad1=7, din1=0xA5A5; next cycle ren1, rad1=7 and ren2, rad2=7 -> dout1=dout2=0xA5A5 one cycle later, rvalid1=rvalid2=1.
- wen1 wad1=4 din1=0x1111 and wen2 wad2=4 din2=0x2222 on the same edge -> ww_conflict=1 next cycle; later read of entry 4 returns 0x2222.
- Entry 4 holds 0x2222. Same edge: wen1 wad1=4 din1=0xFFFF, ren1 rad1=4 -> collision=1 next cycle, coll_count=1. dout1=0x2222 with BYPASS=0; dout1=0xFFFF with BYPASS=1.
- Hold a read/write collision for 300 cycles with CNT_WIDTH=8 -> coll_count stops at 255. Pulse clr -> coll_count=0, ready=0 for 32 cycles, entry 4 then reads 0x0000.
- Assert reset at cycle 10 of INIT, and again mid-stream of writes -> outputs 0 immediately; full 32-cycle sweep repeats; no writes are accepted during INIT.
